pgm_ddram_arbiter: RTL and testbench
====================================

Name: pgm_ddram_arbiter

Overview:
Shares the single MiSTer DDRAM read port between the PGM video fetch engines and other ROM readers. Typical requesters are sprite A-ROM fetch, background tile fetch and CPU/program ROM. Sits between the requesters (pgm_video and others) and the DDRAM controller. Keeps one read outstanding at a time and routes returned 64-bit data to the requester that owns the read.

Parameters:
N, 3, number of requesters; index 0 has the highest fixed priority.
AW, 29, DDRAM word address width.
STARVE_LIMIT, 64, wait cycles after which a pending requester becomes urgent (only with PGM_ARB_AGING_EN).
AGE_W, 7, width of the per-requester age counter; must satisfy 2^AGE_W > STARVE_LIMIT.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  N  per-requester read request; level, held until gnt
req_addr  in  N*AW  flat address bus; slice i = requester i, valid while req[i]
gnt  out  N  one-hot, one-cycle pulse: request accepted into arbiter
rvalid  out  N  one-hot, one-cycle pulse: rdata belongs to requester i
rdata  out  64  returned read data
ddram_rd  out  1  read strobe to DDRAM
ddram_addr  out  AW  read address
ddram_burstcnt  out  8  constant 1
ddram_dout  in  64  DDRAM read data
ddram_dout_ready  in  1  DDRAM read data valid
ddram_busy  in  1  DDRAM cannot accept a command this cycle

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, ddram_rd=0, ddram_addr=0, ddram_burstcnt=1. State is IDLE and all age counters are 0.
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req bit is high, pick the winner w (lowest index without aging). On the next edge:
  - gnt[w]=1 for exactly one cycle
  - ddram_addr = req_addr slice w, owner latched to w
  - ddram_rd=1, go to ISSUE
  If no req bit is high, stay in IDLE.
- ISSUE: hold ddram_rd and ddram_addr stable while ddram_busy=1. The command is accepted on an edge where ddram_rd=1 and ddram_busy=0. On that edge ddram_rd goes to 0 and the state moves to WAIT.
- WAIT: on the first edge with ddram_dout_ready=1:
  - rdata = ddram_dout
  - rvalid[owner]=1 for one cycle
  - go to IDLE
  rdata holds its value until the next return.
- Best-case timing: req at edge 0, gnt and ddram_rd high after edge 1, accepted at edge 2 if busy=0. Data arriving at edge k gives rvalid after edge k. A new grant is possible the cycle after rvalid, so rvalid and the next gnt can be high in the same cycle.
- req is sampled only in IDLE. A requester that keeps req high the cycle after gnt is treated as a new request.
- ddram_dout_ready outside WAIT is ignored and its data is dropped.
- Simultaneous req on several bits: exactly one gnt bit. The losers keep waiting, no requests are lost.
- Reset mid-transaction: return to IDLE with reset values on the same edge. A late ddram_dout_ready is discarded and no rvalid is produced.
- Invariants: gnt and rvalid are always zero or one-hot. At most one read is outstanding.

Optional Feature:
Macro: PGM_ARB_AGING_EN.
- Defined: each requester has a saturating AGE_W-bit counter.
  - Increments every cycle req[i]=1 without gnt[i].
  - Clears on gnt[i] or when req[i]=0.
  - Requester i is urgent when its counter >= STARVE_LIMIT.
  - In IDLE, urgent requesters beat non-urgent ones; ties go to the lowest index within each class.
- Undefined: no counters are built; pure fixed priority with the lowest index winning.

Test Plan:
- Single read: req=001, addr0=0x0400010, busy=0, dout_ready 5 cycles after accept with dout=0x1122334455667788 -> gnt=001 one cycle; ddram_addr=0x0400010; rvalid=001 with that rdata; ddram_rd high exactly one cycle.
- Busy stall: req=010, busy=1 for 4 cycles -> ddram_rd and ddram_addr stable for 5 cycles, one accept, one rvalid=010.
- Contention: req=111 held and each requester drops req after its gnt -> grants in order 001, 010, 100. Three rvalids with matching data, never two reads outstanding.
- Reset in WAIT: reset pulse, then dout_ready -> no rvalid, all outputs at reset values, next req=100 served normally.
- Stray return: dout_ready in IDLE with no request -> rvalid stays 0 and rdata unchanged.
- Aging (PGM_ARB_AGING_EN, STARVE_LIMIT=8): req[0] re-requests back-to-back while req[2] held -> req[2] granted once its age reaches 8. Without the macro, req[2] is never granted while req[0] keeps requesting.

Source files
------------

// File: rtl/pgm_ddram_arbiter.sv
// Shares one DDRAM read port among N ROM readers, one read outstanding; optional aging via PGM_ARB_AGING_EN.
// Latency: gnt and ddram_rd one cycle after req in IDLE; rvalid one cycle after ddram_dout_ready in WAIT.
// Backpressure: ddram_busy holds the command in ISSUE; losers keep req high and are served in later IDLE cycles.
module pgm_ddram_arbiter #(
    parameter int N            = 3,
    parameter int AW           = 29,
    parameter int STARVE_LIMIT = 64,
    parameter int AGE_W        = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] req_addr,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rvalid,
    output logic [63:0]     rdata,
    output logic            ddram_rd,
    output logic [AW-1:0]   ddram_addr,
    output logic [7:0]      ddram_burstcnt,
    input  logic [63:0]     ddram_dout,
    input  logic            ddram_dout_ready,
    input  logic            ddram_busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   win;
    logic [AW-1:0]   win_addr;
    logic [N-1:0]    urgent;
    logic            grant_en;
    logic            accept_en;
    logic            ret_en;

    if ((1 << AGE_W) <= STARVE_LIMIT) begin : g_cfg_check
        $error("AGE_W too narrow to reach STARVE_LIMIT");
    end

`ifdef PGM_ARB_AGING_EN
    logic [AGE_W-1:0] age [N];

    // Age counts cycles spent requesting without being granted; saturates.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset || !req[i] || gnt[i])
                age[i] <= '0;
            else if (age[i] != {AGE_W{1'b1}})
                age[i] <= age[i] + AGE_W'(1);
        end
    end

    always_comb begin
        urgent = '0;
        for (int i = 0; i < N; i++)
            urgent[i] = req[i] && (age[i] >= AGE_W'(STARVE_LIMIT));
    end
`else
    assign urgent = '0;
`endif

    // Lowest index wins; any urgent requester overrides the plain winner.
    always_comb begin
        win      = '0;
        win_addr = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) win = IW'(i);
        if (|urgent) begin
            for (int i = N - 1; i >= 0; i--)
                if (urgent[i]) win = IW'(i);
        end
        for (int i = 0; i < N; i++)
            if (win == IW'(i)) win_addr = req_addr[i*AW +: AW];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        accept_en = 1'b0;
        ret_en    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_en  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!ddram_busy) begin
                    accept_en = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ddram_dout_ready) begin
                    ret_en    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Returns outside WAIT never reach ret_en, so stray or post-reset data is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt        <= '0;
            rvalid     <= '0;
            rdata      <= '0;
            ddram_rd   <= 1'b0;
            ddram_addr <= '0;
            owner      <= '0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            if (grant_en) begin
                gnt        <= N'(1) << win;
                ddram_addr <= win_addr;
                owner      <= win;
                ddram_rd   <= 1'b1;
            end
            if (accept_en)
                ddram_rd <= 1'b0;
            if (ret_en) begin
                rdata  <= ddram_dout;
                rvalid <= N'(1) << owner;
            end
        end
    end

    assign ddram_burstcnt = 8'd1;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// Directed stimulus with a DDRAM responder; a monitor pops expected grants/returns/strobe lengths and compares.
module tb_pgm_ddram_arbiter;

    localparam int N  = 3;
    localparam int AW = 29;
`ifdef PGM_ARB_AGING_EN
    localparam int SL = 8;
`else
    localparam int SL = 64;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [63:0]     rdata;
    logic            ddram_rd;
    logic [AW-1:0]   ddram_addr;
    logic [7:0]      ddram_burstcnt;
    logic [63:0]     ddram_dout = '0;
    logic            ddram_dout_ready = 1'b0;
    logic            ddram_busy = 1'b0;

    pgm_ddram_arbiter #(.N(N), .AW(AW), .STARVE_LIMIT(SL), .AGE_W(7)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ddram_rd(ddram_rd), .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt),
        .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready), .ddram_busy(ddram_busy)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_g[$];
    logic [66:0] exp_r[$];
    int          exp_len[$];

    int checks = 0;
    int errors = 0;

    int            busy_left = 0;
    int            lat = 1;
    int            lat_cnt = 0;
    int            gcnt = 0;
    int            rvcnt = 0;
    bit            hold0 = 0;
    bit            done = 0;
    logic [AW-1:0] acc_addr = '0;

    int            chk_req = 0;
    string         chk_name;
    logic [N-1:0]  chk_g, chk_rv;
    logic [63:0]   chk_rdata;
    logic          chk_rd;
    logic [AW-1:0] chk_addr;

    function automatic logic [63:0] mem_data(input logic [AW-1:0] a);
        if (a == 29'h0400010) return 64'h1122334455667788;
        return {3'b000, a, 32'h5A5A0000};
    endfunction

    // One clock step: requesters drop after gnt (unless hold0), DDRAM model responds.
    task automatic cyc();
        logic          acc;
        logic [AW-1:0] a;
        acc = ddram_rd && !ddram_busy;
        a   = ddram_addr;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gcnt++;
                if (!(hold0 && i == 0)) req[i] = 1'b0;
            end
        end
        if (rvalid != '0) rvcnt++;
        ddram_dout_ready = 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                ddram_dout_ready = 1'b1;
                ddram_dout       = mem_data(acc_addr);
            end
        end
        if (acc) begin
            lat_cnt  = lat;
            acc_addr = a;
        end
        ddram_busy = ddram_rd && (busy_left > 0);
        if (ddram_busy) busy_left--;
    endtask

    task automatic wait_rv(input int target, input int budget);
        int n;
        n = 0;
        while (rvcnt < target) begin
            cyc();
            n++;
            if (n > budget) begin
                $display("FAIL timeout waiting rvalid: got %0d want %0d", rvcnt, target);
                $fatal(1, "bench stalled");
            end
        end
    endtask

    task automatic expect_read(input logic [N-1:0] g, input logic [AW-1:0] a,
                               input logic [63:0] d, input int len);
        exp_g.push_back({g, a});
        exp_r.push_back({g, d});
        exp_len.push_back(len);
    endtask

    task automatic snap(input string nm, input logic [N-1:0] g, input logic [N-1:0] rv,
                        input logic [63:0] rd, input logic rdv, input logic [AW-1:0] a);
        chk_name  = nm;
        chk_g     = g;
        chk_rv    = rv;
        chk_rdata = rd;
        chk_rd    = rdv;
        chk_addr  = a;
        chk_req++;
    endtask

    initial begin : monitor
        int            rd_len;
        int            chk_done;
        bit            moved;
        bit            outst;
        logic [AW-1:0] rd_a0;
        logic [31:0]   eg;
        logic [66:0]   er;
        int            el;
        rd_len = 0; chk_done = 0; moved = 0; outst = 0; rd_a0 = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_len = 0; moved = 0; outst = 0;
            end else begin
                if (gnt != '0) begin
                    checks++;
                    if (exp_g.size() == 0) begin
                        errors++;
                        $display("FAIL gnt unexpected: got %b addr %h", gnt, ddram_addr);
                    end else begin
                        eg = exp_g.pop_front();
                        if ({gnt, ddram_addr} !== eg || ddram_rd !== 1'b1) begin
                            errors++;
                            $display("FAIL gnt: got %b addr %h rd %b, want %b addr %h rd 1",
                                     gnt, ddram_addr, ddram_rd, eg[31:29], eg[28:0]);
                        end
                    end
                end
                if (rvalid != '0) begin
                    outst = 0;
                    checks++;
                    if (exp_r.size() == 0) begin
                        errors++;
                        $display("FAIL rvalid unexpected: got %b data %h", rvalid, rdata);
                    end else begin
                        er = exp_r.pop_front();
                        if ({rvalid, rdata} !== er) begin
                            errors++;
                            $display("FAIL rvalid: got %b data %h, want %b data %h",
                                     rvalid, rdata, er[66:64], er[63:0]);
                        end
                    end
                end
                if (ddram_rd) begin
                    if (rd_len == 0) rd_a0 = ddram_addr;
                    else if (ddram_addr !== rd_a0) moved = 1;
                    rd_len++;
                    if (!ddram_busy) begin
                        checks++;
                        if (outst) begin
                            errors++;
                            $display("FAIL outstanding: got second accept, want at most one read");
                        end
                        outst = 1;
                    end
                end else if (rd_len != 0) begin
                    checks++;
                    el = (exp_len.size() == 0) ? -1 : exp_len.pop_front();
                    if (rd_len != el || moved) begin
                        errors++;
                        $display("FAIL rd_strobe: got %0d cycles moved %0d, want %0d cycles stable",
                                 rd_len, moved, el);
                    end
                    rd_len = 0; moved = 0;
                end
                if (chk_req != chk_done) begin
                    chk_done = chk_req;
                    checks++;
                    if ({gnt, rvalid, rdata, ddram_rd, ddram_addr, ddram_burstcnt} !==
                        {chk_g, chk_rv, chk_rdata, chk_rd, chk_addr, 8'd1}) begin
                        errors++;
                        $display("FAIL %s: got gnt %b rv %b rdata %h rd %b addr %h bc %0d, want gnt %b rv %b rdata %h rd %b addr %h bc 1",
                                 chk_name, gnt, rvalid, rdata, ddram_rd, ddram_addr, ddram_burstcnt,
                                 chk_g, chk_rv, chk_rdata, chk_rd, chk_addr);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_g.size() != 0 || exp_r.size() != 0 || exp_len.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: got %0d/%0d/%0d pending, want 0/0/0",
                             exp_g.size(), exp_r.size(), exp_len.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin : stimulus
        int g0;
        int n;
        repeat (3) cyc();
        reset = 1'b0;
        snap("reset_state", '0, '0, 64'h0, 1'b0, '0);
        cyc();

        // Single read, data returned five steps after accept.
        lat = 5;
        req_addr[0*AW +: AW] = 29'h0400010;
        req = 3'b001;
        expect_read(3'b001, 29'h0400010, 64'h1122334455667788, 1);
        wait_rv(1, 40);

        // Stray return in IDLE must be ignored.
        ddram_dout       = 64'hDEADBEEFCAFEF00D;
        ddram_dout_ready = 1'b1;
        cyc();
        snap("stray_return", '0, '0, 64'h1122334455667788, 1'b0, 29'h0400010);
        cyc();

        // Busy stall: four busy cycles keep the strobe up for five.
        lat = 3;
        busy_left = 4;
        req_addr[1*AW +: AW] = 29'h0000ABC;
        req = 3'b010;
        expect_read(3'b010, 29'h0000ABC, mem_data(29'h0000ABC), 5);
        wait_rv(2, 40);

        // Contention: all three request together, served by index order.
        lat = 2;
        req_addr[0*AW +: AW] = 29'h1000001;
        req_addr[1*AW +: AW] = 29'h1000002;
        req_addr[2*AW +: AW] = 29'h1000003;
        req = 3'b111;
        expect_read(3'b001, 29'h1000001, mem_data(29'h1000001), 1);
        expect_read(3'b010, 29'h1000002, mem_data(29'h1000002), 1);
        expect_read(3'b100, 29'h1000003, mem_data(29'h1000003), 1);
        wait_rv(5, 100);

        // Reset while waiting for data; the late return must vanish.
        lat = 8;
        req_addr[0*AW +: AW] = 29'h0123456;
        exp_g.push_back({3'b001, 29'h0123456});
        exp_len.push_back(1);
        g0 = gcnt;
        req = 3'b001;
        n = 0;
        while (!(gcnt == g0 + 1 && !ddram_rd)) begin
            cyc();
            n++;
            if (n > 50) begin
                $display("FAIL timeout waiting accept before reset");
                $fatal(1, "bench stalled");
            end
        end
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        snap("reset_in_wait", '0, '0, 64'h0, 1'b0, '0);
        repeat (12) cyc();

        lat = 2;
        req_addr[2*AW +: AW] = 29'h1FFFFFFF;
        req = 3'b100;
        expect_read(3'b100, 29'h1FFFFFFF, mem_data(29'h1FFFFFFF), 1);
        wait_rv(6, 40);

        // Requester 0 re-requests continuously while requester 2 waits.
        lat = 1;
        req_addr[0*AW +: AW] = 29'h0000100;
        req_addr[2*AW +: AW] = 29'h0000200;
        hold0 = 1;
        expect_read(3'b001, 29'h0000100, mem_data(29'h0000100), 1);
        expect_read(3'b001, 29'h0000100, mem_data(29'h0000100), 1);
`ifdef PGM_ARB_AGING_EN
        expect_read(3'b100, 29'h0000200, mem_data(29'h0000200), 1);
`else
        expect_read(3'b001, 29'h0000100, mem_data(29'h0000100), 1);
`endif
        expect_read(3'b001, 29'h0000100, mem_data(29'h0000100), 1);
        expect_read(3'b001, 29'h0000100, mem_data(29'h0000100), 1);
        expect_read(3'b001, 29'h0000100, mem_data(29'h0000100), 1);
        g0 = gcnt;
        req = 3'b101;
        n = 0;
        while (gcnt < g0 + 6) begin
            cyc();
            n++;
            if (n > 100) begin
                $display("FAIL timeout waiting grants in aging run");
                $fatal(1, "bench stalled");
            end
        end
        hold0 = 0;
        req = '0;
        wait_rv(12, 40);

        repeat (4) cyc();
        done = 1;
        repeat (5) @(posedge clk);
        $display("FAIL summary not reached");
        $fatal(1, "bench stalled");
    end

endmodule
